bnn_uart_tx: RTL
================

Name: bnn_uart_tx

Overview:
UART transmitter for the BNN controller's return path. It serialises classification result bytes onto UART_Tx as 8N1 frames and paces each bit from the external baud_clk pin. It honours host flow control on UART_RTS and buffers results in a small FIFO, so the inference datapath never stalls on the serial link. It sits inside bnn_controller, opposite the existing UART receive path.

Parameters:
DATA_BITS, 8, payload bits per frame, sent LSB first
FIFO_DEPTH, 4, result FIFO entries; must be a power of 2, minimum 2
SYNC_STAGES, 2, flops in each synchroniser for baud_clk and UART_RTS; minimum 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-high (the top level drives ~rst_n onto it)
baud_clk  input  1  external bit-rate clock, asynchronous to clk; one rising edge per bit period
UART_RTS  input  1  host ready-to-receive, asynchronous; high = host may accept frames
tx_data  input  DATA_BITS  result byte to send
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept a byte
UART_Tx  output  1  serial line; idle high
busy  output  1  a frame is in progress (state is not IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (async assert): UART_Tx=1, busy=0, fifo_count=0, tx_ready=1, state=IDLE; synchroniser flops=0, shift register and bit counter=0.
- Reset mid-frame: UART_Tx returns to 1 immediately. The frame is truncated and all FIFO contents are discarded.
- Synchronisers:
  - baud_clk and UART_RTS each pass through SYNC_STAGES flops.
  - tick is a one-clk pulse on the 0->1 transition of synchronised baud_clk, detected with one extra history flop.
  - Every UART_Tx change happens on the clk edge at which tick=1.
- FIFO:
  - tx_ready = (fifo_count != FIFO_DEPTH). It is combinational from count only and never depends on a same-cycle pop.
  - push = tx_valid && tx_ready. pop happens only under the FSM conditions below.
  - Push and pop in the same cycle: count unchanged, data ordering preserved.
  - Pop is only possible when count>0 at the start of the cycle, so a byte pushed into an empty FIFO cannot pop in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - tx_valid while full: the byte is not accepted and no state changes. The producer must hold the byte.
- start_ok = (fifo_count>0) && rts_sync.
- FSM:
  - IDLE: UART_Tx=1. On a tick with start_ok: pop the FIFO into the shift register, UART_Tx=0, go to START.
  - START: on tick, UART_Tx=shift[0], shift right, bit counter=1, go to DATA.
  - DATA: on tick, if counter<DATA_BITS: UART_Tx=shift[0], shift, counter+1. If counter==DATA_BITS: UART_Tx=1, go to STOP.
  - STOP: on tick, if start_ok: pop, UART_Tx=0, go to START. This gives back-to-back frames with no idle bit. Otherwise go to IDLE with UART_Tx=1.
- Every bit, including start and stop, lasts exactly one tick-to-tick period. A frame is DATA_BITS+2 periods.
- Flow control:
  - UART_RTS is sampled only at frame boundaries (IDLE or STOP on tick).
  - RTS falling mid-frame does not abort the frame; it only blocks the next start.
- busy=1 in START, DATA and STOP.
- No tick: the FSM holds its state and UART_Tx is stable indefinitely.

Test Plan:
1. Reset values: assert rst_n with baud_clk toggling -> UART_Tx=1, busy=0, fifo_count=0, tx_ready=1. Release rst_n with no push -> UART_Tx stays 1 for 20 baud periods.
2. Single byte: RTS=1, push 0xA5 -> UART_Tx bits per baud period are 0, 1,0,1,0,0,1,0,1, 1; busy high for exactly 10 periods; fifo_count 1->0 at the start bit.
3. Back-to-back: RTS=1, push 0x00 then 0xFF -> 20 contiguous bit periods 0,00000000,1,0,11111111,1 with no idle bit between frames.
4. Full FIFO with RTS=0: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> first four accepted, fifo_count=4, tx_ready=0, 0x55 not accepted, UART_Tx stays 1. Raise RTS -> frames for 0x11,0x22,0x33,0x44 in order; tx_ready returns to 1 after the first pop.
5. RTS drop mid-frame: RTS=1, queue 0x3C,0xC3; drop RTS during data bit 4 of 0x3C -> 0x3C completes with stop bit, then UART_Tx idles high and fifo_count=1. Raise RTS -> 0xC3 frame follows.
6. Reset mid-frame: assert rst_n during data bit 2 of 0x5A with 2 bytes queued -> UART_Tx=1 immediately, fifo_count=0. After release, no frame until a new push.

Source files
------------

// File: rtl/bnn_uart_tx_if.sv
// Producer-side byte handshake into the UART transmit FIFO.
interface bnn_uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bnn_uart_tx.sv
// 8N1 UART transmitter for BNN results: small FIFO, bit pacing from an external
// baud clock, and host RTS flow control checked only between frames.
module bnn_uart_tx #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_clk,
  input  logic                          UART_RTS,
  bnn_uart_tx_if.slave                  tx,
  output logic                          UART_Tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [SYNC_STAGES-1:0] baud_sync_reg;
  logic [SYNC_STAGES-1:0] rts_sync_reg;
  logic                   baud_hist_reg;
  logic                   tick;
  logic                   rts_s;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [AW:0]            count_reg;
  logic                   push;
  logic                   pop;
  logic                   start_ok;

  state_t                 state_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [CW-1:0]          bit_cnt_reg;
  logic                   tx_line_reg;

  // Both asynchronous inputs are resynchronised; the extra history flop turns
  // the synchronised baud clock into a single-cycle bit tick.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      baud_sync_reg <= '0;
      rts_sync_reg  <= '0;
      baud_hist_reg <= 1'b0;
    end else begin
      baud_sync_reg <= {baud_sync_reg[SYNC_STAGES-2:0], baud_clk};
      rts_sync_reg  <= {rts_sync_reg[SYNC_STAGES-2:0], UART_RTS};
      baud_hist_reg <= baud_sync_reg[SYNC_STAGES-1];
    end
  end

  assign tick  = baud_sync_reg[SYNC_STAGES-1] & ~baud_hist_reg;
  assign rts_s = rts_sync_reg[SYNC_STAGES-1];

  assign tx.tx_ready = (count_reg != (AW+1)'(FIFO_DEPTH));
  assign push        = tx.tx_valid && tx.tx_ready;
  assign start_ok    = (count_reg != '0) && rts_s;
  assign pop         = tick && start_ok && ((state_reg == IDLE) || (state_reg == STOP));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx.tx_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Every line transition happens on a tick; without ticks the FSM is frozen.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_line_reg <= 1'b1;
    end else if (tick) begin
      case (state_reg)
        IDLE, STOP: begin
          if (pop) begin
            shift_reg   <= mem[rd_ptr_reg];
            tx_line_reg <= 1'b0;
            state_reg   <= START;
          end else begin
            tx_line_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        START: begin
          tx_line_reg <= shift_reg[0];
          shift_reg   <= shift_reg >> 1;
          bit_cnt_reg <= CW'(1);
          state_reg   <= DATA;
        end
        DATA: begin
          if (bit_cnt_reg < CW'(DATA_BITS)) begin
            tx_line_reg <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else begin
            tx_line_reg <= 1'b1;
            state_reg   <= STOP;
          end
        end
        default: begin
          tx_line_reg <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign UART_Tx    = tx_line_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_count = count_reg;
endmodule
